// File: rtl/axis_debug_slip_deframer.sv
// SLIP deframer feeding the debug AXIS chain through a commit/rollback FIFO.
// Define AXIS_DEBUG_SLIP_STATS_EN to add saturating frame/error/overflow counters.
module axis_debug_slip_deframer #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_ON_RST = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_m_axis_tvalid,
    input  logic        i_m_axis_tready,
    output logic [7:0]  o_m_axis_tdata,
    output logic        o_m_axis_tlast,
    output logic        o_frame_error,
    output logic        o_overflow
`ifdef AXIS_DEBUG_SLIP_STATS_EN
    ,
    output logic [15:0] o_frame_count,
    output logic [15:0] o_error_count,
    output logic [15:0] o_overflow_count
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IN_FRAME,
        ST_ESCAPE,
        ST_DISCARD
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rd_q, wr_spec_q, wr_spec_d, wr_commit_q, wr_commit_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_vld_q, hold_vld_d;
    logic [8:0]      mem_q [FIFO_DEPTH];

    logic            full;
    logic            load, end_in, rollback;
    logic [7:0]      data_in;
    logic            wr_en, commit;
    logic            ferr_d, ovf_d;
    logic            tvalid, pop;

    assign tvalid = (rd_q != wr_commit_q);
    assign pop    = tvalid && i_m_axis_tready;
    assign o_m_axis_tvalid = tvalid;

    always_comb begin
        o_m_axis_tlast = 1'b0;
        o_m_axis_tdata = '0;
        if (tvalid) begin
            {o_m_axis_tlast, o_m_axis_tdata} = mem_q[rd_q[AW-1:0]];
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        wr_spec_d   = wr_spec_q;
        wr_commit_d = wr_commit_q;
        load        = 1'b0;
        end_in      = 1'b0;
        rollback    = 1'b0;
        data_in     = '0;
        wr_en       = 1'b0;
        commit      = 1'b0;
        ferr_d      = 1'b0;
        ovf_d       = 1'b0;
        // Uses rd before any same-cycle pop, so full is conservative.
        full        = ((wr_spec_q - rd_q) == DEPTH_P);

        if (i_rx_valid) begin
            unique case (state_q)
                ST_SYNC: begin
                    if (i_rx_data == SLIP_END) state_d = ST_IN_FRAME;
                end
                ST_IN_FRAME: begin
                    if (i_rx_data == SLIP_END) begin
                        end_in = 1'b1;
                    end else if (i_rx_data == SLIP_ESC) begin
                        state_d = ST_ESCAPE;
                    end else begin
                        load    = 1'b1;
                        data_in = i_rx_data;
                    end
                end
                ST_ESCAPE: begin
                    if (i_rx_data == SLIP_ESC_END) begin
                        load    = 1'b1;
                        data_in = SLIP_END;
                        state_d = ST_IN_FRAME;
                    end else if (i_rx_data == SLIP_ESC_ESC) begin
                        load    = 1'b1;
                        data_in = SLIP_ESC;
                        state_d = ST_IN_FRAME;
                    end else begin
                        ferr_d   = 1'b1;
                        rollback = 1'b1;
                        state_d  = (i_rx_data == SLIP_END) ? ST_IN_FRAME : ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (i_rx_data == SLIP_END) state_d = ST_IN_FRAME;
                end
                default: state_d = ST_SYNC;
            endcase
        end

        // Hold byte is flushed into the FIFO by the next data byte or END.
        if ((load || end_in) && hold_vld_q) begin
            if (full) begin
                ovf_d    = 1'b1;
                rollback = 1'b1;
                state_d  = ST_DISCARD;
            end else begin
                wr_en  = 1'b1;
                commit = end_in;
            end
        end

        if (rollback) begin
            wr_spec_d  = wr_commit_q;
            hold_vld_d = 1'b0;
        end else if (wr_en) begin
            wr_spec_d = wr_spec_q + PW'(1);
            if (commit) begin
                wr_commit_d = wr_spec_q + PW'(1);
                hold_vld_d  = 1'b0;
            end else begin
                hold_d = data_in;
            end
        end else if (load) begin
            hold_d     = data_in;
            hold_vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_spec_q[AW-1:0]] <= {commit, hold_q};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= (SYNC_ON_RST != 0) ? ST_SYNC : ST_IN_FRAME;
            rd_q          <= '0;
            wr_spec_q     <= '0;
            wr_commit_q   <= '0;
            hold_q        <= '0;
            hold_vld_q    <= 1'b0;
            o_frame_error <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_spec_q     <= wr_spec_d;
            wr_commit_q   <= wr_commit_d;
            hold_q        <= hold_d;
            hold_vld_q    <= hold_vld_d;
            o_frame_error <= ferr_d;
            o_overflow    <= ovf_d;
            if (pop) rd_q <= rd_q + PW'(1);
        end
    end

`ifdef AXIS_DEBUG_SLIP_STATS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_count    <= '0;
            o_error_count    <= '0;
            o_overflow_count <= '0;
        end else begin
            if (commit && (o_frame_count != '1))    o_frame_count    <= o_frame_count + 16'd1;
            if (ferr_d && (o_error_count != '1))    o_error_count    <= o_error_count + 16'd1;
            if (ovf_d && (o_overflow_count != '1))  o_overflow_count <= o_overflow_count + 16'd1;
        end
    end
`endif

endmodule
